dm_cmd_arbiter: RTL

Shares one datamover command/status channel pair (MM2S or S2MM side) between NUM_REQ requesters. Round-robin arbitration; builds the 72-bit datamover command word with tag = requester index. Routes each returned 8-bit status to its owner and raises a sticky per-requester interrupt. Sits between the stream-master control logic and the datamover, replacing a single hard-wired command source per direction.

---
 rtl/dm_cmd_pkg.sv | 17 +
 rtl/dm_cmd_arbiter_rr_arbiter.sv | 27 ++
 rtl/dm_cmd_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/dm_cmd_pkg.sv
// dm_cmd_pkg: datamover command/status field layout and arbiter FSM state type.
package dm_cmd_pkg;
    localparam int TAG_W         = 4;
    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_ADDR_LSB  = 32;
    localparam logic CMD_TYPE_INCR = 1'b1;
    localparam int STS_TAG_LSB   = 0;
    localparam int STS_FLAGS_LSB = 4;
    localparam logic [3:0] DONE_INTERR = 4'b0001;

    typedef enum logic {
        CMD_IDLE  = 1'b0,
        CMD_VALID = 1'b1
    } cmd_state_t;
endpackage

// File: rtl/dm_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Scan downward so the nearest request to ptr is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
                any = 1'b1;
            end
        end
    end

    assign grant = any ? (ONE << idx) : '0;
endmodule

// File: rtl/dm_cmd_arbiter.sv
// dm_cmd_arbiter: round-robin sharing of one datamover cmd/status pair among NUM_REQ requesters.
module dm_cmd_arbiter
    import dm_cmd_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int BTT_WIDTH  = 23,
    parameter int CMD_WIDTH  = ADDR_WIDTH + 40
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BTT_WIDTH-1:0]  req_btt,
    input  logic [NUM_REQ-1:0]            req_eof,
    output logic                          cmd_tvalid,
    input  logic                          cmd_tready,
    output logic [CMD_WIDTH-1:0]          cmd_tdata,
    input  logic                          sts_tvalid,
    output logic                          sts_tready,
    input  logic [7:0]                    sts_tdata,
    output logic [NUM_REQ-1:0]            done_valid,
    output logic [NUM_REQ*4-1:0]          done_status,
    output logic [NUM_REQ-1:0]            irq_pending,
    input  logic [NUM_REQ-1:0]            irq_clear,
    output logic                          irq,
    output logic                          proto_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    cmd_state_t state, state_n;
    logic run, any, take, btt_nz, sts_hit;
    logic [NUM_REQ-1:0] busy, eligible, grant, sts_set, zero_set, done_set;
    logic [IW-1:0] rr_ptr, gidx;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [BTT_WIDTH-1:0] g_btt;
    logic [TAG_W-1:0] sts_tag;
    logic [15:0] busy16;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d;

    assign eligible = req_valid & ~busy;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req  (eligible),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (gidx),
        .any  (any)
    );

    assign g_addr   = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_btt    = req_btt[int'(gidx)*BTT_WIDTH +: BTT_WIDTH];
    assign take     = run && state == CMD_IDLE && any;
    assign btt_nz   = |g_btt;
    assign sts_tag  = sts_tdata[STS_TAG_LSB +: TAG_W];
    assign busy16   = 16'(busy);
    assign sts_hit  = int'(sts_tag) < NUM_REQ && busy16[sts_tag];
    assign sts_set  = (run && sts_tvalid && sts_hit) ? (ONE << sts_tag) : '0;
    assign zero_set = (take && !btt_nz) ? grant : '0;
    assign done_set = sts_set | zero_set;
    assign sts_tready = run;
    assign cmd_tdata  = cmd_q;

    always_comb begin
        cmd_d = '0;
        cmd_d[CMD_BTT_LSB +: BTT_WIDTH] = g_btt;
        cmd_d[CMD_TYPE_BIT] = CMD_TYPE_INCR;
        cmd_d[CMD_EOF_BIT] = req_eof[gidx];
        cmd_d[CMD_ADDR_LSB +: ADDR_WIDTH] = g_addr;
        cmd_d[CMD_ADDR_LSB + ADDR_WIDTH +: TAG_W] = TAG_W'(gidx);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= CMD_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = (state == CMD_IDLE) ? ((take && btt_nz) ? CMD_VALID : CMD_IDLE)
                                      : (cmd_tready ? CMD_IDLE : CMD_VALID);
    end

    always_comb begin
        cmd_tvalid = state == CMD_VALID;
        req_ready  = take ? grant : '0;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run         <= 1'b0;
            rr_ptr      <= '0;
            busy        <= '0;
            cmd_q       <= '0;
            done_valid  <= '0;
            done_status <= '0;
            irq_pending <= '0;
            irq         <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            run         <= 1'b1;
            busy        <= (busy & ~sts_set) | ((take && btt_nz) ? grant : '0);
            done_valid  <= done_set;
            irq_pending <= (irq_pending & ~irq_clear) | done_set;
            irq         <= |irq_pending;
            proto_err   <= proto_err | (run && sts_tvalid && !sts_hit);
            if (take) rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
            if (take && btt_nz) cmd_q <= cmd_d;
            for (int i = 0; i < NUM_REQ; i++)
                if (done_set[i])
                    done_status[i*4 +: 4] <= zero_set[i] ? DONE_INTERR : sts_tdata[STS_FLAGS_LSB +: 4];
        end
    end
endmodule
